// File: rtl/motor_cmd_sequencer_pkg.sv
// motor_cmd_sequencer_pkg: shared FSM state type and RF bit map for the motor command sequencer
package motor_cmd_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, REV_WAIT, LIMIT} state_t;
    localparam int RF_DIR0    = 0;
    localparam int RF_DIR1    = 1;
    localparam int RF_RUN0    = 2;
    localparam int RF_RUN1    = 3;
    localparam int NUM_MOTORS = 2;
endpackage

// File: rtl/motor_cmd_sequencer_input_debouncer.sv
// input_debouncer: 2-FF synchroniser, stability-count debouncer and rising-edge press pulse
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_CNT_W        = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);
    logic                r_s1, r_s2, r_deb, r_deb_d;
    logic [DB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            if (r_s2 == r_deb)
                r_cnt <= '0;
            else if (r_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_press = r_deb & ~r_deb_d;
endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: conditions RF/limit inputs and runs one enable/direction FSM per stepper motor
module motor_cmd_sequencer
    import motor_cmd_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_CNT_W        = 20,
    parameter int PAUSE_TICKS     = 8,
    parameter int PAUSE_CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            rf_input,
    input  logic [NUM_MOTORS-1:0] limit_switches,
    input  logic                  step_tick,
    output logic [NUM_MOTORS-1:0] dir,
    output logic [NUM_MOTORS-1:0] en,
    output logic [NUM_MOTORS-1:0] fault
);
    logic [3:0]            w_press;
    logic [NUM_MOTORS-1:0] r_lim_s1, r_lim_s2;

    for (genvar k = 0; k < 4; k++) begin : g_db
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_CNT_W       (DB_CNT_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (rf_input[k]),
            .o_press(w_press[k])
        );
    end

    // Limits skip debouncing so protection acts within the synchroniser delay
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lim_s1 <= '0;
            r_lim_s2 <= '0;
        end else begin
            r_lim_s1 <= limit_switches;
            r_lim_s2 <= r_lim_s1;
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_motor
        localparam int RUN_IDX = (i == 0) ? RF_RUN0 : RF_RUN1;
        localparam int DIR_IDX = (i == 0) ? RF_DIR0 : RF_DIR1;
        state_t                 r_state, w_state;
        logic                   r_dir, w_dir, r_en, r_fault;
        logic [PAUSE_CNT_W-1:0] r_pause, w_pause;
        logic                   w_run, w_dp, w_lim;

        assign w_run = w_press[RUN_IDX];
        assign w_dp  = w_press[DIR_IDX];
        assign w_lim = r_lim_s2[i];

        always_comb begin
            w_state = r_state;
            w_dir   = r_dir;
            w_pause = r_pause;
            case (r_state)
                IDLE:
                    if (w_run)
                        w_state = (w_lim && r_dir) ? LIMIT : RUN;
                    else if (w_dp)
                        w_dir = ~r_dir;
                RUN:
                    if (w_lim && r_dir)
                        w_state = LIMIT;
                    else if (w_run)
                        w_state = IDLE;
                    else if (w_dp) begin
                        w_state = REV_WAIT;
                        w_pause = '0;
                    end
                REV_WAIT:
                    if (w_run)
                        w_state = IDLE;
                    else if (step_tick) begin
                        w_pause = r_pause + 1'b1;
                        if (w_pause == PAUSE_CNT_W'(PAUSE_TICKS)) begin
                            w_dir   = ~r_dir;
                            w_state = (~r_dir && w_lim) ? LIMIT : RUN;
                        end
                    end
                LIMIT:
                    if (w_run)
                        w_state = IDLE;
                    else if (w_dp) begin
                        w_dir   = ~r_dir;
                        w_state = IDLE;
                    end
                default: w_state = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= IDLE;
                r_dir   <= 1'b0;
                r_pause <= '0;
                r_en    <= 1'b0;
                r_fault <= 1'b0;
            end else begin
                r_state <= w_state;
                r_dir   <= w_dir;
                r_pause <= w_pause;
                r_en    <= (w_state == RUN);
                r_fault <= (w_state == LIMIT);
            end
        end

        assign dir[i]   = r_dir;
        assign en[i]    = r_en;
        assign fault[i] = r_fault;
    end
endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Command sequencer between the RF receiver / limit-switch inputs and the two stepper drivers.
- Conditions raw inputs with synchronisers and debouncers, then turns button presses into run/stop and direction commands.
- A per-motor FSM gates each driver's enable, including a pause before any direction reversal while running and latched forward-limit protection.
- Outputs feed the drivers' dir/en inputs directly. The step tick comes from the existing clock divider.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before a debounced rf bit changes (10 ms at 100 MHz)
DB_CNT_W, 20, debounce counter width; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES
PAUSE_TICKS, 8, step_tick pulses with enable low before a running motor reverses (minimum 1)
PAUSE_CNT_W, 4, pause counter width; must satisfy 2^PAUSE_CNT_W > PAUSE_TICKS

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-low reset
rf_input  in  4  raw RF buttons, async, active-high; [0] dir motor0, [1] dir motor1, [2] run motor0, [3] run motor1
limit_switches  in  2  raw forward-limit switches, async, active-high; [i] belongs to motor i
step_tick  in  1  one-clk pulse at step rate, from the clock divider
dir  out  2  registered direction per motor; 1 = forward
en  out  2  registered driver enable per motor
fault  out  2  per-motor forward-limit latched indicator

Behaviour:
- Reset (rst=0, asynchronous): dir=0, en=0, fault=0, all FSMs IDLE, synchronisers/debounced values/counters cleared to 0.
- Input conditioning:
  - Every rf bit passes a 2-FF synchroniser, then a debouncer. The debounced value adopts the synced value only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement resets the counter.
  - press[k] is a one-cycle pulse on the debounced rising edge. Releases generate nothing.
  - limit_switches: 2-FF synchroniser only, no debounce, so they act immediately.
- Latency:
  - Clean rf edge to en/dir change: DEBOUNCE_CYCLES+3 clk.
  - Limit edge to en low: 3 clk.
- FSM per motor i; run_press = press[2+i], dir_press = press[i], lim = synced limit_switches[i].
- IDLE (en=0):
  - run_press: if lim && dir=1, go to LIMIT; else go to RUN.
  - dir_press: toggle dir, stay in IDLE.
- RUN (en=1):
  - lim && dir=1: go to LIMIT.
  - else run_press: go to IDLE.
  - else dir_press: go to REV_WAIT, clearing the pause counter.
- REV_WAIT (en=0):
  - Each step_tick increments the pause counter.
  - On the tick that reaches PAUSE_TICKS: toggle dir, then go to LIMIT if the new dir=1 && lim, else to RUN.
  - run_press: go to IDLE; dir is unchanged and the pending reversal is discarded.
  - dir_press: ignored.
- LIMIT (en=0, fault=1):
  - Stays latched even after lim deasserts.
  - run_press: go to IDLE.
  - dir_press: toggle dir and go to IDLE.
- Priority within one cycle: lim-forward condition > run_press > dir_press > tick expiry.
- The two motor FSMs are fully independent. Simultaneous presses on both motors are each processed in the same cycle.
- Reverse motion (dir=0) is never blocked by lim.
- en, dir and fault are registered outputs with no combinational path from the inputs.
- Reset asserted mid-pause or mid-debounce: everything returns to reset values immediately and any partial counts are lost.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, RUN, REV_WAIT, LIMIT; 2-bit encoding).
  - rf bit index constants (RF_DIR0=0, RF_DIR1=1, RF_RUN0=2, RF_RUN1=3).
  - Motor count constant NUM_MOTORS=2.
- Sub-module input_debouncer: 2-FF sync, stability counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES/DB_CNT_W. Instantiated 4 times.
- The per-motor FSM stays in a generate loop inside the top module.

Test Plan:
(Bench parameters DEBOUNCE_CYCLES=4, PAUSE_TICKS=2.)
1. Reset then rf_input[2] held high 10 clk -> en[0] rises exactly 7 clk after the edge; dir=00, fault=00. A second press -> en[0]=0.
2. Bounce rf_input[3] high/low every 2 clk for 20 clk, then release -> en[1] never changes, no press generated.
3. Motor0 RUN with dir[0]=0, press rf_input[0], then 2 step_tick pulses -> en[0]=0 from 1 clk after the press; after the 2nd tick dir[0]=1 and en[0]=1 on the next clk.
4. Motor1 RUN, dir[1]=1, assert limit_switches[1] -> en[1]=0 and fault[1]=1 within 3 clk. Deassert limit -> fault stays 1. Press dir -> dir[1]=0, fault[1]=0, IDLE.
5. dir[0]=1 with limit_switches[0]=1 in IDLE, press run -> goes to LIMIT, en[0] stays 0, fault[0]=1. Press dir, then run -> RUN with dir[0]=0, en[0]=1.
6. REV_WAIT after 1 tick, pulse rst low -> all outputs 0 asynchronously. Release rst -> IDLE, dir=00.
